hc595_chain_driver: RTL
=======================

// Module: hc595_chain_driver
// PURPOSE
//  Transmit side of the 74x595 serial interface. Takes one parallel word per handshake and shifts it
//  MSB-first into a chain of N_CHIPS cascaded 74x595s via SER/SRCLK. It then pulses RCLK to transfer the
//  word to the chip outputs. Sits between core logic and board-level 74x595 banks. Drives the pins
//  the chip model consumes.
// PARAMETERS
//  N_CHIPS  1  number of cascaded 74x595 devices
//  WIDTH    8*N_CHIPS  word width; derived, not to be overridden
//  CLK_DIV  1  CLK cycles per SRCLK/RCLK phase (half-period); CLK_DIV<1 is an elaboration error
// PORTS
//  CLK    in   1      system clock; all state changes on rising edge
//  RST    in   1      synchronous reset, active-high
//  DATA   in   WIDTH  word to transmit; sampled on accept
//  VALID  in   1      DATA valid
//  READY  out  1      block idle, can accept
//  SER    out  1      serial data to first chip SER pin
//  SRCLK  out  1      shift clock to all chips
//  RCLK   out  1      storage-register clock to all chips
//  OE_N   out  1      output enable to all chips, active-low
// BEHAVIOUR
//  Clock and reset: one clock, CLK; reset is synchronous and active-high, RST.
//  Reset values: SER=0, SRCLK=0, RCLK=0, OE_N=1, READY=1 (state IDLE), shift reg=0, counters=0.
//  All outputs are registered; no combinational path from inputs to outputs.
//  Handshake: a word is accepted on an edge where VALID&READY. READY drops the next cycle.
//   VALID while !READY is ignored. DATA need not be held after accept.
//  FSM (states defined in hc595_pkg):
//   IDLE   -> SHIFT_L on accept: load shreg=DATA, bitcnt=WIDTH, SER=DATA[WIDTH-1], SRCLK=0
//   SHIFT_L -> SHIFT_H after CLK_DIV cycles; SRCLK=1; SER is held stable, giving a setup of CLK_DIV cycles
//   SHIFT_H -> after CLK_DIV cycles: SRCLK=0, shreg<<=1, bitcnt-=1;
//              if bitcnt was 1 -> LATCH (RCLK=1), else SHIFT_L with SER=next MSB
//   LATCH  -> IDLE after CLK_DIV cycles; RCLK=0, SER=0, OE_N=0, READY=1
//  Bit order: DATA[WIDTH-1] is shifted first and ends in the last chip's QH.
//   DATA[0] ends in the first chip's QA.
//  Timing: with accept at edge t, READY=1 again at edge t+1+2*CLK_DIV*WIDTH+CLK_DIV.
//   With WIDTH=8 and CLK_DIV=1, READY returns at t+18. SRCLK shows exactly WIDTH rising edges per word.
//   RCLK shows exactly one pulse, CLK_DIV cycles wide. RCLK never rises while SRCLK=1.
//  OE_N: held 1 from reset until the first LATCH completes, then 0 until the next RST.
//   This prevents power-up garbage from reaching the outputs.
//  Back-to-back: an accept in the same cycle READY rises is legal.
//   It starts SHIFT_L the following cycle, with no idle gap.
//  Reset mid-transfer: the next edge forces all reset values and discards the word. No RCLK pulse is emitted.
//  Phase counter width is $clog2(CLK_DIV+1). bitcnt width is $clog2(WIDTH+1). No wrap is permitted in either.
// STRUCTURE
//  hc595_pkg: state enum typedef (IDLE, SHIFT_L, SHIFT_H, LATCH) and BITS_PER_CHIP=8 constant.
//  Sub-module hc595_phase_timer: loadable down-counter that asserts done after CLK_DIV cycles.
//   It is reused for every phase.
//  Top level: FSM, shift register, bit counter, output registers.
// TESTING (bench includes a behavioural 74x595 chain model to check parallel outputs)
//  1. Reset with N_CHIPS=1, CLK_DIV=1 -> outputs at reset values; OE_N=1; READY=1.
//     Send 8'hA5 at t -> 8 SRCLK rises; SER sequence 1,0,1,0,0,1,0,1; RCLK pulse at t+17;
//     READY and OE_N=0 at t+18; model outputs QH..QA=A5.
//  2. N_CHIPS=2, CLK_DIV=3: send 16'h1234 -> 16 SRCLK edges, each phase 3 cycles;
//     chip1 outputs 8'h12, chip0 outputs 8'h34; READY returns at t+1+96+3.
//  3. Back-to-back: hold VALID high with 8'hFF then 8'h00 -> second accept on the cycle READY rises;
//     outputs go FF then 00; exactly 2 RCLK pulses.
//  4. VALID pulsed while busy (8'h0F mid-shift) -> ignored; outputs equal the first word only;
//     one RCLK pulse.
//  5. RST asserted at the 5th SRCLK of 8'hC3 -> next edge: SRCLK=0, RCLK never pulses, OE_N=1;
//     model storage is unchanged; the next word transmits correctly.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared definitions for the 74x595 chain driver.
// Holds the transmit FSM state type and the number of bits each 74x595 contributes to the chain.
package hc595_pkg;

    // Transmit FSM states: wait for a word, drive SRCLK low/high per bit, then pulse RCLK
    typedef enum logic [1:0] {
        IDLE,
        SHIFT_L,
        SHIFT_H,
        LATCH
    } hc595_state_e;

    localparam int BITS_PER_CHIP = 8;

endpackage

// File: rtl/hc595_phase_timer.sv
// Loadable down-counter that times one SRCLK/RCLK phase.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high (counter cleared, done_o high)
//   load_i      start a new phase this edge
//   loadLong_i  when loading, stretch the phase by one extra cycle
//   done_o      phase has run its full length; high while the counter sits at zero
module hc595_phase_timer
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic loadLong_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A normal load of CLK_DIV-1 makes done_o appear CLK_DIV cycles after the load edge.
    // The long load (CLK_DIV) adds one cycle so the first bit gets extra SER setup after accept.
    // The counter parks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadLong_i ? CNT_W'(CLK_DIV) : CNT_W'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hc595_chain_driver.sv
// Transmit side of the 74x595 serial interface.
// Accepts one parallel word per VALID/READY handshake, shifts it MSB-first into N_CHIPS cascaded
// 74x595s over SER/SRCLK, then pulses RCLK to move it to the chip outputs.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high
//   data_i   word to transmit, sampled on accept
//   valid_i  data_i valid
//   ready_o  idle and able to accept a word
//   ser_o    serial data to the first chip's SER pin
//   srclk_o  shift clock to all chips
//   rclk_o   storage-register clock to all chips
//   oe_n_o   output enable to all chips, active-low
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter  int N_CHIPS = 1,
    parameter  int CLK_DIV = 1,
    localparam int WIDTH   = BITS_PER_CHIP * N_CHIPS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             srclk_o,
    output logic             rclk_o,
    output logic             oe_n_o
);

    localparam int BCW = $clog2(WIDTH + 1);

    if (CLK_DIV < 1) begin : g_badClkDiv
        $error("hc595_chain_driver: CLK_DIV must be at least 1");
    end

    hc595_state_e     state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [BCW-1:0]   bitCnt_q;
    logic             srclk_q;
    logic             rclk_q;
    logic             oeN_q;
    logic             ready_q;

    logic accept;
    logic timerLoad;
    logic timerLong;
    logic timerDone;

    // READY is only ever high in IDLE, so it alone qualifies the handshake
    assign accept = valid_i && ready_q;

    // Restart the phase timer on accept (stretched first phase) and whenever a phase completes
    always_comb begin
        timerLoad = 1'b0;
        timerLong = 1'b0;
        if (state_q == IDLE) begin
            timerLoad = accept;
            timerLong = 1'b1;
        end else begin
            timerLoad = timerDone;
        end
    end

    hc595_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phaseTimer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timerLoad),
        .loadLong_i(timerLong),
        .done_o    (timerDone)
    );

    // Transmit FSM. SER is the shift register MSB, so it changes only when SRCLK falls and
    // naturally returns to zero once all WIDTH bits have been shifted out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            srclk_q    <= 1'b0;
            rclk_q     <= 1'b0;
            oeN_q      <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shiftReg_q <= data_i;
                        bitCnt_q   <= BCW'(WIDTH);
                        srclk_q    <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= SHIFT_L;
                    end
                end
                SHIFT_L: begin
                    if (timerDone) begin
                        srclk_q <= 1'b1;
                        state_q <= SHIFT_H;
                    end
                end
                SHIFT_H: begin
                    if (timerDone) begin
                        srclk_q    <= 1'b0;
                        shiftReg_q <= {shiftReg_q[WIDTH-2:0], 1'b0};
                        bitCnt_q   <= bitCnt_q - BCW'(1);
                        if (bitCnt_q == BCW'(1)) begin
                            rclk_q  <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            state_q <= SHIFT_L;
                        end
                    end
                end
                LATCH: begin
                    if (timerDone) begin
                        rclk_q  <= 1'b0;
                        oeN_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign ser_o   = shiftReg_q[WIDTH-1];
    assign srclk_o = srclk_q;
    assign rclk_o  = rclk_q;
    assign oe_n_o  = oeN_q;

endmodule
